// File: rtl/ahb_mem_slave.sv
// AHB-Lite responder backed by a word-organised RAM with programmable wait states.
// Define AHB_MEM_SLAVE_ERR_EN to enable range/size/alignment checks with a two-cycle ERROR response.
module ahb_mem_slave #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e            r_state;
  logic              r_hreadyout;
  logic              r_hresp;
  logic              r_write;
  logic [2:0]        r_size;
  logic [1:0]        r_addr_lo;
  logic [IdxW-1:0]   r_idx;
  logic [3:0]        r_wait_cnt;
  logic [31:0]       r_hrdata;
  logic [31:0]       r_mem [MEM_DEPTH];

  logic              w_accept;
  logic              w_illegal;
  logic              w_rd_phase;
  logic [29:0]       w_word;
  logic [IdxW-1:0]   w_idx;
  logic [3:0]        w_lane_en;

  assign w_accept = HSEL & HREADY & HTRANS[1];
  assign w_word   = HADDR[31:2];
  // Legal indices are already in range, so the modulo only matters for aliasing without checks.
  assign w_idx    = IdxW'(w_word % 30'(MEM_DEPTH));

`ifdef AHB_MEM_SLAVE_ERR_EN
  assign w_illegal = ({2'b00, w_word} >= 32'(MEM_DEPTH)) | (HSIZE > 3'd2) |
                     ((HSIZE == 3'd1) & HADDR[0]) |
                     ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
`else
  assign w_illegal = 1'b0;
`endif

  // Byte lanes; halfword/word ignore the low address bits below their alignment.
  always_comb begin
    w_lane_en = 4'b0000;
    case (r_size)
      3'd0:    w_lane_en[r_addr_lo] = 1'b1;
      3'd1:    w_lane_en = r_addr_lo[1] ? 4'b1100 : 4'b0011;
      default: w_lane_en = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (r_state == StData && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lane_en[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= StIdle;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_write     <= 1'b0;
      r_size      <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_idx       <= '0;
      r_wait_cnt  <= 4'd0;
    end else begin
      unique case (r_state)
        StWait: begin
          if (r_wait_cnt == 4'd0) begin
            r_state     <= StData;
            r_hreadyout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        StErr1: begin
          r_state     <= StErr2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all close with HREADYOUT high, so a new address phase may land.
          if (w_accept) begin
            r_addr_lo <= HADDR[1:0];
            r_write   <= HWRITE;
            r_size    <= HSIZE;
            r_idx     <= w_idx;
            if (w_illegal) begin
              r_state     <= StErr1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              r_state     <= StWait;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
              r_wait_cnt  <= 4'(WAIT_STATES - 1);
            end else begin
              r_state     <= StData;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end
          end else begin
            r_state     <= StIdle;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign w_rd_phase = (r_state == StData) && !r_write;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_hrdata <= 32'd0;
    end else if (w_rd_phase) begin
      r_hrdata <= r_mem[r_idx];
    end
  end

  // Read data is taken straight from the RAM so a write closing on the same edge is visible.
  assign HRDATA    = w_rd_phase ? r_mem[r_idx] : r_hrdata;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

endmodule
